// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampling tick generator, two-flop synchroniser,
// majority-voted frame FSM and a valid/ready holding register with error/overrun flags.
module uart_rx_param #(
  parameter int system_clock     = 25000000,
  parameter int rx_baudrate      = 9600,
  parameter int rx_sampling_rate = 16,
  parameter int data_bits        = 8,
  parameter int parity_mode      = 0,
  parameter int stop_bits        = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_input,
  input  logic                 rx_enable,
  input  logic                 rx_ready,
  output logic [data_bits-1:0] rx_output,
  output logic                 rx_valid,
  output logic                 rx_frame_error,
  output logic                 rx_parity_error,
  output logic                 rx_overrun,
  output logic                 rx_busy,
  output logic                 rx_done
);

  localparam int DIV_RAW = system_clock / (rx_baudrate * rx_sampling_rate);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int S_W     = $clog2(rx_sampling_rate);
  localparam int M       = rx_sampling_rate / 2;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [S_W-1:0]   S_LAST    = S_W'(rx_sampling_rate - 1);
  localparam logic [S_W-1:0]   S_V0      = S_W'(M - 1);
  localparam logic [S_W-1:0]   S_V1      = S_W'(M);
  localparam logic [S_W-1:0]   S_DEC     = S_W'(M + 1);
  localparam logic [3:0]       DATA_LAST = 4'(data_bits - 1);
  localparam logic [3:0]       STOP_LAST = 4'(stop_bits - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [DIV_W-1:0]     div_q, div_d;
  logic                 tick;
  logic                 sync1_q, sync2_q, line;
  logic                 armed_q, armed_d;
  logic [2:0]           state_q, state_d;
  logic [S_W-1:0]       s_q, s_d;
  logic [3:0]           bit_q, bit_d;
  logic [data_bits-1:0] shift_q, shift_d;
  logic                 v0_q, v0_d, v1_q, v1_d;
  logic                 ferr_q, ferr_d, perr_q, perr_d;
  logic [data_bits-1:0] out_q, out_d;
  logic                 valid_q, valid_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 maj, dec, wrap, exp_par, complete, hs;

  assign tick    = (div_q == DIV_LAST);
  assign line    = sync2_q;
  assign maj     = maj3(v0_q, v1_q, line);
  assign dec     = (s_q == S_DEC);
  assign wrap    = (s_q == S_LAST);
  assign exp_par = (parity_mode == 2) ? ^shift_q : ~^shift_q;
  assign hs      = valid_q & rx_ready;

  always_comb begin
    div_d      = tick ? '0 : div_q + DIV_W'(1);
    armed_d    = armed_q;
    state_d    = state_q;
    s_d        = s_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    ferr_d     = ferr_q;
    perr_d     = perr_q;
    busy_d     = busy_q;
    complete   = 1'b0;
    out_d      = out_q;
    valid_d    = valid_q;
    ferr_out_d = ferr_out_q;
    perr_out_d = perr_out_q;
    ovr_d      = ovr_q;

    if (tick) begin
      if (state_q == IDLE) begin
        // armed blocks re-triggering on a line that stayed low after the last frame
        if (line) begin
          armed_d = 1'b1;
        end else if (armed_q && rx_enable) begin
          state_d = START;
          s_d     = '0;
          bit_d   = '0;
          busy_d  = 1'b1;
          ferr_d  = 1'b0;
          perr_d  = 1'b0;
        end
      end else begin
        s_d = wrap ? '0 : s_q + S_W'(1);
        if (s_q == S_V0) v0_d = line;
        if (s_q == S_V1) v1_d = line;
        case (state_q)
          START: begin
            if (dec && maj) begin
              state_d = IDLE;
              s_d     = '0;
              busy_d  = 1'b0;
            end else if (wrap) begin
              state_d = DATA;
              bit_d   = '0;
            end
          end
          DATA: begin
            if (dec) shift_d = {maj, shift_q[data_bits-1:1]};
            if (wrap) begin
              if (bit_q == DATA_LAST) begin
                bit_d   = '0;
                state_d = (parity_mode != 0) ? PARITY : STOP;
              end else begin
                bit_d = bit_q + 4'd1;
              end
            end
          end
          PARITY: begin
            if (dec) perr_d = (maj != exp_par);
            if (wrap) begin
              state_d = STOP;
              bit_d   = '0;
            end
          end
          STOP: begin
            // finish at the last stop bit's decision point so a back-to-back start is not missed
            if (dec) begin
              if (!maj) ferr_d = 1'b1;
              if (bit_q == STOP_LAST) begin
                complete = 1'b1;
                state_d  = IDLE;
                s_d      = '0;
                armed_d  = 1'b0;
                busy_d   = 1'b0;
              end
            end else if (wrap) begin
              bit_d = bit_q + 4'd1;
            end
          end
          default: begin
            state_d = IDLE;
            s_d     = '0;
            busy_d  = 1'b0;
          end
        endcase
      end
    end

    if (hs) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (complete) begin
      if (!valid_q || hs) begin
        valid_d    = 1'b1;
        out_d      = shift_q;
        ferr_out_d = ferr_d;
        perr_out_d = perr_q;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign done_d = complete;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      armed_q    <= 1'b1;
      state_q    <= IDLE;
      s_q        <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      ferr_out_q <= 1'b0;
      perr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      div_q      <= div_d;
      sync1_q    <= rx_input;
      sync2_q    <= sync1_q;
      armed_q    <= armed_d;
      state_q    <= state_d;
      s_q        <= s_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      ferr_out_q <= ferr_out_d;
      perr_out_q <= perr_out_d;
      ovr_q      <= ovr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rx_output       = out_q;
  assign rx_valid        = valid_q;
  assign rx_frame_error  = ferr_out_q;
  assign rx_parity_error = perr_out_q;
  assign rx_overrun      = ovr_q;
  assign rx_busy         = busy_q;
  assign rx_done         = done_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance and a 7E2 instance, directed cases plus
// randomized 7E2 frames scored against a word/flag holding-register model.
module tb_uart_rx_param;

  localparam int BIT_CLK = 32;
  localparam int NOLIM   = 100000;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx8, en8, rdy8;
  logic [7:0] out8;
  logic       valid8, ferr8, perr8, ovr8, busy8, done8;
  logic       rx7, en7, rdy7;
  logic [6:0] out7;
  logic       valid7, ferr7, perr7, ovr7, busy7, done7;

  int n_checks = 0;
  int n_fail   = 0;
  int done8_cnt = 0, done7_cnt = 0, busy8_cnt = 0;

  always #5 clk = ~clk;

  uart_rx_param #(
    .system_clock(3200000), .rx_baudrate(100000), .rx_sampling_rate(16),
    .data_bits(8), .parity_mode(0), .stop_bits(1)
  ) u_rx8 (
    .clk(clk), .rst(rst), .rx_input(rx8), .rx_enable(en8), .rx_ready(rdy8),
    .rx_output(out8), .rx_valid(valid8), .rx_frame_error(ferr8),
    .rx_parity_error(perr8), .rx_overrun(ovr8), .rx_busy(busy8), .rx_done(done8)
  );

  uart_rx_param #(
    .system_clock(3200000), .rx_baudrate(100000), .rx_sampling_rate(16),
    .data_bits(7), .parity_mode(2), .stop_bits(2)
  ) u_rx7 (
    .clk(clk), .rst(rst), .rx_input(rx7), .rx_enable(en7), .rx_ready(rdy7),
    .rx_output(out7), .rx_valid(valid7), .rx_frame_error(ferr7),
    .rx_parity_error(perr7), .rx_overrun(ovr7), .rx_busy(busy7), .rx_done(done7)
  );

  always @(posedge clk) begin
    if (done8) done8_cnt <= done8_cnt + 1;
    if (done7) done7_cnt <= done7_cnt + 1;
    if (busy8) busy8_cnt <= busy8_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // which: 0 = 8N1 line, 1 = 7E2 line. bad_stop = index of a low stop bit (-1 none).
  task automatic send(input int which, input logic [8:0] d, input bit flip_par,
                      input int bad_stop, input int spike_clk, input int max_clk);
    logic [15:0] bits;
    logic [8:0]  dm;
    logic        lv;
    int          n, nd, ns;
    nd   = (which != 0) ? 7 : 8;
    ns   = (which != 0) ? 2 : 1;
    dm   = (which != 0) ? {2'b00, d[6:0]} : {1'b0, d[7:0]};
    bits = '0;
    n    = 1;
    for (int i = 0; i < nd; i++) begin
      bits[n] = dm[i];
      n++;
    end
    if (which != 0) begin
      bits[n] = (^dm) ^ flip_par;
      n++;
    end
    for (int i = 0; i < ns; i++) begin
      bits[n] = (bad_stop == i) ? 1'b0 : 1'b1;
      n++;
    end
    for (int c = 0; c < n * BIT_CLK && c < max_clk; c++) begin
      lv = bits[c / BIT_CLK] ^ (c == spike_clk);
      if (which != 0) rx7 = lv; else rx8 = lv;
      @(negedge clk);
    end
    if (which != 0) rx7 = 1'b1; else rx8 = 1'b1;
  endtask

  task automatic pulse_ready(input int which);
    if (which != 0) rdy7 = 1'b1; else rdy8 = 1'b1;
    @(negedge clk);
    rdy7 = 1'b0;
    rdy8 = 1'b0;
    @(negedge clk);
  endtask

  int         d0, b0, bs;
  bit         flip;
  logic [8:0] rd;
  bit         mvalid, movr, mperr, mferr;
  logic [6:0] mword;

  initial begin
    rst = 1'b1; rx8 = 1'b1; rx7 = 1'b1; en8 = 1'b1; en7 = 1'b1; rdy8 = 1'b0; rdy7 = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_out8",   32'(out8), 0);
    chk("rst_valid8", 32'(valid8), 0);
    chk("rst_flags8", 32'({ferr8, perr8, ovr8}), 0);
    chk("rst_busy8",  32'(busy8), 0);
    chk("rst_done8",  32'(done8), 0);
    chk("rst_valid7", 32'(valid7), 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // 8N1 0xA5 held with ready low
    d0 = done8_cnt;
    send(0, 9'h0A5, 1'b0, -1, -1, NOLIM);
    repeat (8) @(negedge clk);
    chk("a5_done",  32'(done8_cnt - d0), 1);
    chk("a5_valid", 32'(valid8), 1);
    chk("a5_data",  32'(out8), 32'h A5);
    chk("a5_ferr",  32'(ferr8), 0);
    chk("a5_perr",  32'(perr8), 0);
    chk("a5_busy",  32'(busy8), 0);
    pulse_ready(0);
    chk("a5_clr",   32'(valid8), 0);

    // 10-clk glitch on idle line: false start
    d0 = done8_cnt; b0 = busy8_cnt;
    rx8 = 1'b0;
    repeat (10) @(negedge clk);
    rx8 = 1'b1;
    repeat (80) @(negedge clk);
    chk("glitch_started", 32'(busy8_cnt > b0), 1);
    chk("glitch_done",    32'(done8_cnt - d0), 0);
    chk("glitch_valid",   32'(valid8), 0);
    chk("glitch_busy",    32'(busy8), 0);

    // single-clk spike mid data bit 3 of 0xFF
    d0 = done8_cnt;
    send(0, 9'h0FF, 1'b0, -1, 4 * BIT_CLK + 17, NOLIM);
    repeat (8) @(negedge clk);
    chk("spike_done", 32'(done8_cnt - d0), 1);
    chk("spike_data", 32'(out8), 32'hFF);
    chk("spike_ferr", 32'(ferr8), 0);
    pulse_ready(0);

    // back-to-back overrun
    d0 = done8_cnt;
    send(0, 9'h011, 1'b0, -1, -1, NOLIM);
    send(0, 9'h022, 1'b0, -1, -1, NOLIM);
    repeat (8) @(negedge clk);
    chk("ovr_done",  32'(done8_cnt - d0), 2);
    chk("ovr_data",  32'(out8), 32'h11);
    chk("ovr_flag",  32'(ovr8), 1);
    chk("ovr_valid", 32'(valid8), 1);
    pulse_ready(0);
    chk("ovr_clr_valid", 32'(valid8), 0);
    chk("ovr_clr_flag",  32'(ovr8), 0);

    // break: line low for 20 bit times
    d0 = done8_cnt;
    rx8 = 1'b0;
    repeat (20 * BIT_CLK) @(negedge clk);
    chk("brk_done",  32'(done8_cnt - d0), 1);
    chk("brk_data",  32'(out8), 0);
    chk("brk_ferr",  32'(ferr8), 1);
    chk("brk_valid", 32'(valid8), 1);
    chk("brk_busy",  32'(busy8), 0);
    rx8 = 1'b1;
    repeat (40) @(negedge clk);
    pulse_ready(0);
    d0 = done8_cnt;
    send(0, 9'h03C, 1'b0, -1, -1, NOLIM);
    repeat (8) @(negedge clk);
    chk("brk_after_done", 32'(done8_cnt - d0), 1);
    chk("brk_after_data", 32'(out8), 32'h3C);
    chk("brk_after_ferr", 32'(ferr8), 0);

    // async reset during data bit 4 with 0x3C still held
    d0 = done8_cnt;
    send(0, 9'h0C3, 1'b0, -1, -1, 5 * BIT_CLK + 16);
    rst = 1'b1;
    #1;
    chk("mrst_out",   32'(out8), 0);
    chk("mrst_valid", 32'(valid8), 0);
    chk("mrst_busy",  32'(busy8), 0);
    chk("mrst_flags", 32'({ferr8, perr8, ovr8}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("mrst_nodone", 32'(done8_cnt - d0), 0);
    send(0, 9'h05A, 1'b0, -1, -1, NOLIM);
    repeat (8) @(negedge clk);
    chk("mrst_after_done", 32'(done8_cnt - d0), 1);
    chk("mrst_after_data", 32'(out8), 32'h5A);
    pulse_ready(0);

    // rx_enable low: frame ignored
    en8 = 1'b0;
    d0 = done8_cnt; b0 = busy8_cnt;
    send(0, 9'h096, 1'b0, -1, -1, NOLIM);
    repeat (40) @(negedge clk);
    chk("dis_busy",  32'(busy8_cnt - b0), 0);
    chk("dis_done",  32'(done8_cnt - d0), 0);
    chk("dis_valid", 32'(valid8), 0);
    en8 = 1'b1;

    // 7E2 directed parity cases
    d0 = done7_cnt;
    send(1, 9'h035, 1'b0, -1, -1, NOLIM);
    repeat (4) @(negedge clk);
    chk("e2_done", 32'(done7_cnt - d0), 1);
    chk("e2_data", 32'(out7), 32'h35);
    chk("e2_perr", 32'(perr7), 0);
    chk("e2_ferr", 32'(ferr7), 0);
    pulse_ready(1);
    send(1, 9'h035, 1'b1, -1, -1, NOLIM);
    repeat (4) @(negedge clk);
    chk("e2_bad_data", 32'(out7), 32'h35);
    chk("e2_bad_perr", 32'(perr7), 1);
    chk("e2_bad_ferr", 32'(ferr7), 0);
    pulse_ready(1);

    // randomized 7E2 frames against the holding-register model
    mvalid = 1'b0; movr = 1'b0; mperr = 1'b0; mferr = 1'b0; mword = '0;
    for (int k = 0; k < 12; k++) begin
      rd   = 9'($urandom_range(0, 127));
      flip = ($urandom_range(0, 2) == 0);
      bs   = int'($urandom_range(0, 4));
      if (bs > 1) bs = -1;
      d0 = done7_cnt;
      send(1, rd, flip, bs, -1, NOLIM);
      repeat (4) @(negedge clk);
      if (!mvalid) begin
        mvalid = 1'b1;
        mword  = rd[6:0];
        mperr  = flip;
        mferr  = (bs >= 0);
      end else begin
        movr = 1'b1;
      end
      chk("rnd_done",  32'(done7_cnt - d0), 1);
      chk("rnd_valid", 32'(valid7), 32'(mvalid));
      chk("rnd_data",  32'(out7), 32'(mword));
      chk("rnd_perr",  32'(perr7), 32'(mperr));
      chk("rnd_ferr",  32'(ferr7), 32'(mferr));
      chk("rnd_ovr",   32'(ovr7), 32'(movr));
      if ($urandom_range(0, 1) == 1) begin
        pulse_ready(1);
        mvalid = 1'b0;
        movr   = 1'b0;
        chk("rnd_hs_valid", 32'(valid7), 0);
        chk("rnd_hs_ovr",   32'(ovr7), 0);
      end
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
